// File: rtl/div_iter.sv
// div_iter: iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// It takes one operand pair per start and needs 32 cycles of iteration.
// The quotient feeds LO and the remainder feeds HI. Both are held until the
// next operation completes.
// Build option: define DIV_ZERO_FAST_EN so that a zero divisor completes one
// cycle after start instead of running the full iteration.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FAST = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Control strobes decoded from the FSM.
  logic load;
  logic step;
  logic finish;
  logic fast_fin;

  // Iteration registers.
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_reg;   // 33-bit partial remainder
  logic [WIDTH-1:0] dvd_reg;   // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] dvs_reg;   // divisor magnitude
  logic             q_neg;
  logic             r_neg;
  logic             dz_flag;

  // One restoring step.
  logic [WIDTH+1:0] shift_rem;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Two's complement negate. The most negative value wraps onto itself.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of an operand. It is only taken for a signed operation.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && (sv < 0)) ? negate(v) : v;
  endfunction

  // Conditional negation for the final sign correction.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? negate(v) : v;
  endfunction

  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    fast_fin  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (divisor == '0) ? S_FAST : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FAST: begin
        fast_fin  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift, trial-subtract and restore, plus the sign-corrected results of the final step.
  always_comb begin
    shift_rem = {rem_reg, dvd_reg[WIDTH-1]};
    trial     = shift_rem - {2'b00, dvs_reg};
    q_bit     = ~trial[WIDTH+1];
    rem_nxt   = q_bit ? trial[WIDTH:0] : shift_rem[WIDTH:0];
    dvd_nxt   = {dvd_reg[WIDTH-2:0], q_bit};
    q_fin     = apply_sign(dvd_nxt, q_neg);
    r_fin     = apply_sign(rem_nxt[WIDTH-1:0], r_neg);
  end

  // Operand capture on start, then one restoring step per CALC cycle.
  // With a zero divisor the raw dividend is loaded and both signs are cleared.
  // Every trial then succeeds: the quotient becomes all ones, and the
  // dividend bits shift unchanged into the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rem_reg <= '0;
      dvd_reg <= '0;
      dvs_reg <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_flag <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      rem_reg <= '0;
      dvs_reg <= magnitude(divisor, is_signed);
      dz_flag <= (divisor == '0);
      if (divisor == '0) begin
        dvd_reg <= dividend;
        q_neg   <= 1'b0;
        r_neg   <= 1'b0;
      end else begin
        dvd_reg <= magnitude(dividend, is_signed);
        q_neg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg   <= is_signed & dividend[WIDTH-1];
      end
    end else if (step) begin
      cnt     <= cnt + CNT_W'(1);
      rem_reg <= rem_nxt;
      dvd_reg <= dvd_nxt;
    end
  end

  // Result registers and the done pulse. Results hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (finish) begin
        q    <= q_fin;
        r    <= r_fin;
        dz   <= dz_flag;
        done <= 1'b1;
      end else if (fast_fin) begin
        q    <= '1;
        r    <= dvd_reg;
        dz   <= 1'b1;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an
// arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        dz;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, with fixed results for zero divisors and overflow.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edz);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa  = a;
    sb  = b;
    edz = (b == 32'd0);
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (!sg) begin
      eq = a / b;
      er = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000;
      er = 32'd0;
    end else begin
      eq = sa / sb;
      er = sa % sb;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 1 : 32;
`else
    return (b == 32'd0) ? 32 : 32;
`endif
  endfunction

  // Issue one operation and wait (bounded) for its done.
  // A nonzero poke re-asserts start with junk operands in that cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input int poke);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    int          bcnt;
    bit          got;
    model(a, b, sg, eq, er, edz);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/done_low_after_start"}, 32'(done), 32'd0);
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (busy) bcnt++;
      if (i == poke) begin
        start = 1'b1; is_signed = ~sg;
        dividend = $urandom; divisor = 32'($urandom_range(1, 9));
      end else begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat(b)));
    check({tag, "/busy_cycles"}, 32'(bcnt), 32'(exp_lat(b)));
    check({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "/q"}, q, eq);
    check({tag, "/r"}, r, er);
    check({tag, "/dz"}, 32'(dz), 32'(edz));
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int          dcnt;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    // Reset state.
    @(posedge clk); #1;
    check("reset/q", q, 32'd0);
    check("reset/r", r, 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/dz", 32'(dz), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations. Consecutive calls also exercise start in the done cycle.
    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 0);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("udiv_5_9", 32'd5, 32'd9, 1'b0, 0);
    run_op("div_zero_u", 32'h1234_5678, 32'd0, 1'b0, 0);
    run_op("div_zero_s", 32'hF234_5678, 32'd0, 1'b1, 0);
    run_op("udiv_poke", 32'd1000, 32'd3, 1'b0, 10);
    run_op("sdiv_poke", 32'hFFFF_FC18, 32'd7, 1'b1, 10);

    // Results hold while idle.
    repeat (6) @(posedge clk);
    #1;
    check("hold/q", q, last_q);
    check("hold/r", r, last_r);
    check("hold/done", 32'(done), 32'd0);

    // Reset in the middle of an operation.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midrst/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/q", q, 32'd0);
    check("midrst/r", r, 32'd0);
    check("midrst/dz", 32'(dz), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("midrst/no_done", 32'(dcnt), 32'd0);
    check("midrst/q_still_zero", q, 32'd0);
    run_op("after_rst_20_3", 32'd20, 32'd3, 1'b0, 0);

    // Randomized operations with a bias toward the edge cases.
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      run_op($sformatf("rand%0d", k), ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
